store_buffer: RTL and testbench
===============================

# store_buffer

Write buffer between `mips_cpu` and `data_memory` on the data port. It accepts CPU stores into a FIFO and retires them to memory in program order when the port is free. Loads are served the same cycle, with youngest-match store-to-load forwarding from the buffer. It decouples the single-cycle core from a data memory that cannot always accept a write.

## Interface
- `DEPTH`, 4, number of buffered stores; power of two, ≥2
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high
- `cpu_a`  in  32  CPU byte address; bits [1:0] ignored (word granularity)
- `cpu_we`  in  1  store request
- `cpu_re`  in  1  load request
- `cpu_wd`  in  32  store data
- `cpu_rd`  out  32  load data
- `cpu_stall`  out  1  store not accepted this cycle; CPU holds PC and request
- `mem_a`  out  32  data memory address
- `mem_we`  out  1  data memory write enable (memory writes on `clk` edge)
- `mem_wd`  out  32  data memory write data
- `mem_rd`  in  32  data memory combinational read data
- `mem_ready`  in  1  memory can accept a write this cycle; tie 1 for `data_memory`
- `empty`  out  1  no pending stores; bench waits on this before dumping RAM

## Operation
- Storage: `DEPTH` entries of {word address [31:2], data [31:0]}; head/tail pointers wrap modulo `DEPTH`; registered `count` of width log2(DEPTH)+1. `full` = (count == DEPTH).
- Enqueue: at the edge where `cpu_we && !full && !reset`, write `cpu_a[31:2]`/`cpu_wd` at tail, then tail+1. No coalescing; duplicate addresses occupy separate entries.
- `cpu_stall` = `cpu_we && full`, combinational from registered `full`. A pop in the same cycle does not unblock the store; the store is accepted on the next edge.
- Drain: `mem_we` = `!empty && !cpu_re && mem_ready`. When `mem_we` = 1: `mem_a` = {head addr, 2'b00}, `mem_wd` = head data, and head advances at the edge.
- Load port: when `cpu_re` = 1, `mem_a` = `cpu_a`, `mem_we` = 0. Loads have port priority over drain.
- Forwarding: on `cpu_re`, all valid entries are compared on [31:2]. On a hit, `cpu_rd` = data of the youngest matching entry (nearest tail). On a miss, `cpu_rd` = `mem_rd`.
- Idle: not loading and not draining gives `mem_a` = `cpu_a`, `mem_we` = 0, `mem_wd` = 0, `cpu_rd` = `mem_rd`.
- `cpu_we && cpu_re` together is a protocol violation. The block treats the cycle as a store only; `cpu_rd` = 0 and no drain occurs that cycle.
- Simultaneous enqueue and pop (not full): count unchanged; both pointers advance.
- Stores retire to memory in exactly acceptance order.

## Timing
- Reset (edge with `reset` = 1): head = tail = count = 0. Outputs from the next cycle: `empty` = 1, `cpu_stall` = 0, `mem_we` = 0, `mem_wd` = 0, `mem_a` = `cpu_a`, `cpu_rd` = `mem_rd`.
- While `reset` is high: `mem_we` forced 0 and stores are dropped. Reset mid-operation discards all pending stores with no memory write.
- Store latency: accepted at edge N. The entry is visible to forwarding in cycle N+1. The earliest memory write is at edge N+1 (`mem_we` high in cycle N+1).
- Load latency: 0 cycles (combinational, same cycle as `cpu_re`).
- Throughput: 1 store accepted and 1 store retired per cycle. A full buffer costs exactly 1 stall cycle per blocked store, provided `mem_ready` = 1 and no load is present.
- `empty` and `cpu_stall` derive from registered state plus current inputs; there is no combinational path from `mem_ready` to `cpu_stall`.

## Test plan
- Reset, then store 0x1234 to 0x8 with `mem_ready` = 1 -> next cycle `mem_we` = 1, `mem_a` = 0x8, `mem_wd` = 0x1234; one cycle later `empty` = 1 and RAM word 2 = 0x1234.
- `mem_ready` = 0; store 0xAA to 0x10; next cycle load 0x10 -> `cpu_rd` = 0xAA, `mem_we` = 0; load 0x14 -> `cpu_rd` = `mem_rd`.
- `mem_ready` = 0; store 1 then 2 to 0x20; load 0x20 -> `cpu_rd` = 2. Raise `mem_ready` -> two writes to 0x20 in order (1 then 2); final RAM = 2.
- `mem_ready` = 0; five consecutive stores (values 10..14 to 0x0..0x10) -> four accepted, fifth sees `cpu_stall` = 1. Raise `mem_ready` -> fifth accepted one edge later; memory receives 10, 11, 12, 13, 14 in order.
- `mem_ready` = 0; three stores buffered, then `reset` pulsed for one cycle -> `empty` = 1, `mem_we` stays 0 after raising `mem_ready`; RAM unchanged.
- Buffer holds 2 entries with `mem_ready` = 1 and `cpu_re` held high 3 cycles -> no drain during those cycles; drain resumes on the first cycle with `cpu_re` = 0.

Source files
------------

// File: rtl/store_buffer.sv
// Store buffer between the CPU data port and data memory: a FIFO of pending
// stores drained in program order, with same-cycle youngest-match load forwarding.
module store_buffer #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] cpu_a,
   input  logic        cpu_we,
   input  logic        cpu_re,
   input  logic [31:0] cpu_wd,
   output logic [31:0] cpu_rd,
   output logic        cpu_stall,
   output logic [31:0] mem_a,
   output logic        mem_we,
   output logic [31:0] mem_wd,
   input  logic [31:0] mem_rd,
   input  logic        mem_ready,
   output logic        empty
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

   logic [29:0]      addr_r [DEPTH];
   logic [31:0]      data_r [DEPTH];
   logic [PW-1:0]    head_r;
   logic [PW-1:0]    tail_r;
   logic [PW:0]      count_r;
   logic             full_s;
   logic             push_s;
   logic             pop_s;
   logic [DEPTH-1:0] slot_hit_s;
   logic             hit_s;
   logic [31:0]      fwd_data_s;

   // full is registered state only, so a same-cycle pop never unblocks a store
   assign full_s    = (count_r == FULL_COUNT);
   assign empty     = (count_r == {(PW+1){1'b0}});
   assign cpu_stall = cpu_we && full_s;
   assign push_s    = cpu_we && !full_s && !reset;
   assign pop_s     = !empty && !cpu_re && mem_ready && !reset;

   // Pointer and occupancy bookkeeping
   always_ff @(posedge clk) begin
      if (reset) begin
         head_r  <= {PW{1'b0}};
         tail_r  <= {PW{1'b0}};
         count_r <= {(PW+1){1'b0}};
      end else begin
         if (push_s) begin
            tail_r <= tail_r + PW'(1);
         end
         if (pop_s) begin
            head_r <= head_r + PW'(1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + (PW+1)'(1);
            2'b01:   count_r <= count_r - (PW+1)'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Entry storage, written at the tail on an accepted store
   always_ff @(posedge clk) begin
      if (push_s) begin
         addr_r[tail_r] <= cpu_a[31:2];
         data_r[tail_r] <= cpu_wd;
      end
   end

   // Forwarding search walks oldest to youngest so the last hit wins
   always_comb begin
      slot_hit_s = {DEPTH{1'b0}};
      hit_s      = 1'b0;
      fwd_data_s = 32'h0000_0000;
      for (int i = 0; i < DEPTH; i++) begin
         slot_hit_s[i] = ((PW+1)'(i) < count_r) &&
                         (addr_r[head_r + PW'(i)] == cpu_a[31:2]);
         hit_s      = hit_s | slot_hit_s[i];
         fwd_data_s = slot_hit_s[i] ? data_r[head_r + PW'(i)] : fwd_data_s;
      end
   end

   // Port arbitration: loads own the port, otherwise drain the head entry
   always_comb begin
      mem_a  = cpu_a;
      mem_we = 1'b0;
      mem_wd = 32'h0000_0000;
      cpu_rd = mem_rd;
      if (cpu_we && cpu_re) begin
         cpu_rd = 32'h0000_0000;
      end else if (cpu_re) begin
         cpu_rd = hit_s ? fwd_data_s : mem_rd;
      end else if (pop_s) begin
         mem_we = 1'b1;
         mem_a  = {addr_r[head_r], 2'b00};
         mem_wd = data_r[head_r];
      end else begin
         cpu_rd = mem_rd;
      end
   end
endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed vector table, hand-written reset sequence,
// and random traffic checked against a queue-based reference model.
module tb_store_buffer;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] cpu_a = 32'h0;
   logic        cpu_we = 1'b0;
   logic        cpu_re = 1'b0;
   logic [31:0] cpu_wd = 32'h0;
   logic [31:0] cpu_rd;
   logic        cpu_stall;
   logic [31:0] mem_a;
   logic        mem_we;
   logic [31:0] mem_wd;
   logic [31:0] mem_rd;
   logic        mem_ready = 1'b1;
   logic        empty;
   logic        ram_clr = 1'b1;
   logic [31:0] ram [64];

   store_buffer #(.DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .cpu_a(cpu_a), .cpu_we(cpu_we), .cpu_re(cpu_re),
      .cpu_wd(cpu_wd), .cpu_rd(cpu_rd), .cpu_stall(cpu_stall), .mem_a(mem_a),
      .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd), .mem_ready(mem_ready),
      .empty(empty)
   );

   always #5 clk = ~clk;

   // Data memory: combinational read, write on the clock edge
   assign mem_rd = ram[mem_a[7:2]];
   always @(posedge clk) begin
      if (ram_clr) begin
         for (int k = 0; k < 64; k++) ram[k] <= 32'h0;
      end else if (mem_we) begin
         ram[mem_a[7:2]] <= mem_wd;
      end
   end

   typedef struct {
      logic        we, re, rdy;
      logic [31:0] a, wd;
      logic        e_we;
      logic [31:0] e_a, e_wd, e_rd;
      logic        e_stall, e_empty;
   } vec_t;
   typedef struct {
      logic [29:0] a;
      logic [31:0] d;
   } ent_t;

   vec_t        tbl[$];
   ent_t        mq[$];
   logic [31:0] ref_mem [64];
   int          n_chk = 0;
   int          n_pass = 0;
   logic [31:0] s_rd, s_a, s_wd;
   logic        s_we, s_stall, s_empty;

   function automatic vec_t v(input logic we, re, input logic [31:0] a, wd, input logic rdy,
                              input logic e_we, input logic [31:0] e_a, e_wd, e_rd,
                              input logic e_stall, e_empty);
      vec_t r;
      r.we = we; r.re = re; r.a = a; r.wd = wd; r.rdy = rdy;
      r.e_we = e_we; r.e_a = e_a; r.e_wd = e_wd; r.e_rd = e_rd;
      r.e_stall = e_stall; r.e_empty = e_empty;
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // One clock cycle: drive, sample at negedge, compare with model, advance model
   task automatic step(input logic rs, we, re, input logic [31:0] a, wd,
                       input logic rdy, input bit chk);
      logic        full_b, drain;
      logic [31:0] e_a, e_wd, e_rd;
      reset = rs; cpu_we = we; cpu_re = re; cpu_a = a; cpu_wd = wd; mem_ready = rdy;
      @(negedge clk);
      s_rd = cpu_rd; s_a = mem_a; s_wd = mem_wd; s_we = mem_we;
      s_stall = cpu_stall; s_empty = empty;
      full_b = (mq.size() == DEPTH);
      drain  = !rs && !re && rdy && (mq.size() != 0);
      e_a    = drain ? {mq[0].a, 2'b00} : a;
      e_wd   = drain ? mq[0].d : 32'h0;
      e_rd   = ref_mem[e_a[7:2]];
      if (we && re) begin
         e_rd = 32'h0;
      end else if (re) begin
         foreach (mq[i]) if (mq[i].a == a[31:2]) e_rd = mq[i].d;
      end
      if (chk) begin
         check("cpu_rd", s_rd, e_rd);
         check("cpu_stall", {31'h0, s_stall}, {31'h0, we && full_b});
         check("mem_we", {31'h0, s_we}, {31'h0, drain});
         check("mem_a", s_a, e_a);
         check("mem_wd", s_wd, e_wd);
         check("empty", {31'h0, s_empty}, {31'h0, mq.size() == 0});
      end
      @(posedge clk);
      if (rs) begin
         mq.delete();
      end else begin
         if (drain) begin
            ref_mem[mq[0].a[5:0]] = mq[0].d;
            void'(mq.pop_front());
         end
         if (we && !full_b) mq.push_back('{a: a[31:2], d: wd});
      end
      #1;
   endtask

   initial begin
      for (int k = 0; k < 64; k++) ref_mem[k] = 32'h0;
      step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      ram_clr = 1'b0;

      tbl.push_back(v(1'b0,1'b0,32'h08,32'h0,   1'b1, 1'b0,32'h08,32'h0,   32'h0,   1'b0,1'b1));
      tbl.push_back(v(1'b1,1'b0,32'h08,32'h1234,1'b1, 1'b0,32'h08,32'h0,   32'h0,   1'b0,1'b1));
      tbl.push_back(v(1'b0,1'b0,32'h00,32'h0,   1'b1, 1'b1,32'h08,32'h1234,32'h0,   1'b0,1'b0));
      tbl.push_back(v(1'b0,1'b1,32'h08,32'h0,   1'b1, 1'b0,32'h08,32'h0,   32'h1234,1'b0,1'b1));
      tbl.push_back(v(1'b1,1'b0,32'h10,32'hAA,  1'b0, 1'b0,32'h10,32'h0,   32'h0,   1'b0,1'b1));
      tbl.push_back(v(1'b0,1'b1,32'h10,32'h0,   1'b0, 1'b0,32'h10,32'h0,   32'hAA,  1'b0,1'b0));
      tbl.push_back(v(1'b0,1'b1,32'h14,32'h0,   1'b0, 1'b0,32'h14,32'h0,   32'h0,   1'b0,1'b0));
      tbl.push_back(v(1'b1,1'b0,32'h20,32'h1,   1'b0, 1'b0,32'h20,32'h0,   32'h0,   1'b0,1'b0));
      tbl.push_back(v(1'b1,1'b0,32'h20,32'h2,   1'b0, 1'b0,32'h20,32'h0,   32'h0,   1'b0,1'b0));
      tbl.push_back(v(1'b0,1'b1,32'h20,32'h0,   1'b0, 1'b0,32'h20,32'h0,   32'h2,   1'b0,1'b0));
      tbl.push_back(v(1'b0,1'b0,32'h00,32'h0,   1'b1, 1'b1,32'h10,32'hAA,  32'h0,   1'b0,1'b0));
      tbl.push_back(v(1'b0,1'b0,32'h00,32'h0,   1'b1, 1'b1,32'h20,32'h1,   32'h0,   1'b0,1'b0));
      tbl.push_back(v(1'b0,1'b0,32'h00,32'h0,   1'b1, 1'b1,32'h20,32'h2,   32'h1,   1'b0,1'b0));
      tbl.push_back(v(1'b0,1'b1,32'h20,32'h0,   1'b1, 1'b0,32'h20,32'h0,   32'h2,   1'b0,1'b1));
      tbl.push_back(v(1'b1,1'b0,32'h00,32'd10,  1'b0, 1'b0,32'h00,32'h0,   32'h0,   1'b0,1'b1));
      tbl.push_back(v(1'b1,1'b0,32'h04,32'd11,  1'b0, 1'b0,32'h04,32'h0,   32'h0,   1'b0,1'b0));
      tbl.push_back(v(1'b1,1'b0,32'h08,32'd12,  1'b0, 1'b0,32'h08,32'h0,   32'h1234,1'b0,1'b0));
      tbl.push_back(v(1'b1,1'b0,32'h0C,32'd13,  1'b0, 1'b0,32'h0C,32'h0,   32'h0,   1'b0,1'b0));
      tbl.push_back(v(1'b1,1'b0,32'h10,32'd14,  1'b0, 1'b0,32'h10,32'h0,   32'hAA,  1'b1,1'b0));
      tbl.push_back(v(1'b1,1'b0,32'h10,32'd14,  1'b1, 1'b1,32'h00,32'd10,  32'h0,   1'b1,1'b0));
      tbl.push_back(v(1'b1,1'b0,32'h10,32'd14,  1'b1, 1'b1,32'h04,32'd11,  32'h0,   1'b0,1'b0));
      tbl.push_back(v(1'b0,1'b0,32'h00,32'h0,   1'b1, 1'b1,32'h08,32'd12,  32'h1234,1'b0,1'b0));
      tbl.push_back(v(1'b0,1'b0,32'h00,32'h0,   1'b1, 1'b1,32'h0C,32'd13,  32'h0,   1'b0,1'b0));
      tbl.push_back(v(1'b0,1'b0,32'h00,32'h0,   1'b1, 1'b1,32'h10,32'd14,  32'hAA,  1'b0,1'b0));
      tbl.push_back(v(1'b0,1'b0,32'h10,32'h0,   1'b1, 1'b0,32'h10,32'h0,   32'd14,  1'b0,1'b1));
      tbl.push_back(v(1'b1,1'b0,32'h30,32'h55,  1'b0, 1'b0,32'h30,32'h0,   32'h0,   1'b0,1'b1));
      tbl.push_back(v(1'b1,1'b0,32'h34,32'h66,  1'b0, 1'b0,32'h34,32'h0,   32'h0,   1'b0,1'b0));
      tbl.push_back(v(1'b0,1'b1,32'h30,32'h0,   1'b1, 1'b0,32'h30,32'h0,   32'h55,  1'b0,1'b0));
      tbl.push_back(v(1'b0,1'b1,32'h34,32'h0,   1'b1, 1'b0,32'h34,32'h0,   32'h66,  1'b0,1'b0));
      tbl.push_back(v(1'b0,1'b1,32'h38,32'h0,   1'b1, 1'b0,32'h38,32'h0,   32'h0,   1'b0,1'b0));
      tbl.push_back(v(1'b0,1'b0,32'h00,32'h0,   1'b1, 1'b1,32'h30,32'h55,  32'h0,   1'b0,1'b0));
      tbl.push_back(v(1'b0,1'b0,32'h00,32'h0,   1'b1, 1'b1,32'h34,32'h66,  32'h0,   1'b0,1'b0));
      tbl.push_back(v(1'b0,1'b0,32'h34,32'h0,   1'b1, 1'b0,32'h34,32'h0,   32'h66,  1'b0,1'b1));
      tbl.push_back(v(1'b1,1'b1,32'h08,32'h77,  1'b1, 1'b0,32'h08,32'h0,   32'h0,   1'b0,1'b1));
      tbl.push_back(v(1'b0,1'b0,32'h00,32'h0,   1'b1, 1'b1,32'h08,32'h77,  32'd12,  1'b0,1'b0));
      tbl.push_back(v(1'b0,1'b1,32'h08,32'h0,   1'b1, 1'b0,32'h08,32'h0,   32'h77,  1'b0,1'b1));

      foreach (tbl[i]) begin
         step(1'b0, tbl[i].we, tbl[i].re, tbl[i].a, tbl[i].wd, tbl[i].rdy, 1'b1);
         check($sformatf("vec%0d_rd", i), s_rd, tbl[i].e_rd);
         check($sformatf("vec%0d_stall", i), {31'h0, s_stall}, {31'h0, tbl[i].e_stall});
         check($sformatf("vec%0d_we", i), {31'h0, s_we}, {31'h0, tbl[i].e_we});
         check($sformatf("vec%0d_a", i), s_a, tbl[i].e_a);
         check($sformatf("vec%0d_wd", i), s_wd, tbl[i].e_wd);
         check($sformatf("vec%0d_empty", i), {31'h0, s_empty}, {31'h0, tbl[i].e_empty});
      end
      check("ram_w0", ram[0], 32'd10);
      check("ram_w2", ram[2], 32'h77);
      check("ram_w4", ram[4], 32'd14);
      check("ram_w8", ram[8], 32'h2);
      check("ram_w13", ram[13], 32'h66);

      // Reset mid-operation discards buffered stores without writing memory
      step(1'b0, 1'b1, 1'b0, 32'h40, 32'h11, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b0, 32'h44, 32'h22, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b0, 32'h48, 32'h33, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         step(1'b0, 1'b0, 1'b0, 32'h40, 32'h0, 1'b1, 1'b1);
         check("rst_empty", {31'h0, s_empty}, 32'h1);
         check("rst_no_write", {31'h0, s_we}, 32'h0);
      end
      check("rst_ram16", ram[16], 32'h0);
      check("rst_ram17", ram[17], 32'h0);
      check("rst_ram18", ram[18], 32'h0);

      for (int k = 0; k < 600; k++) begin
         logic [31:0] ra;
         ra = ({26'h0, 4'($urandom_range(0, 15)), 2'b00}) | 32'($urandom_range(0, 3));
         step($urandom_range(0, 99) == 0, 1'($urandom), $urandom_range(0, 2) == 0,
              ra, $urandom, $urandom_range(0, 3) != 0, 1'b1);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
